// File: rtl/router_pkg.sv
// Shared definitions for the router receive path: header field layout,
// initial TTL, packet-number width and the RX controller state encoding.
package router_pkg;

    localparam int unsigned NUMBER_PACKET_DEF = 19;
    localparam int unsigned PN_W              = $clog2(NUMBER_PACKET_DEF);

    // Header flit layout: [8:0] header_pkt = {TTL, pkt_number, src_router}
    localparam int unsigned SRC_LSB   = 0;
    localparam int unsigned SRC_W     = 2;
    localparam int unsigned PN_LSB    = 2;
    localparam int unsigned TTL_LSB   = 7;
    localparam int unsigned TTL_W     = 2;
    localparam int unsigned HDR_PKT_W = 9;
    localparam int unsigned ADDR_LSB  = 9;
    localparam int unsigned DST_LSB   = 19;

    localparam logic [TTL_W-1:0] TTL_INIT = 2'b10;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_HDR      = 4'd1,
        S_CLASSIFY = 4'd2,
        S_ARB      = 4'd3,
        S_WR       = 4'd4,
        S_SEQ      = 4'd5,
        S_FWD      = 4'd6,
        S_DROP     = 4'd7
    } rx_state_t;

endpackage

// File: rtl/router_hdr_decode.sv
// Combinational split of a header flit into its routing fields, plus a flag
// telling whether the packet is addressed to this router.
module router_hdr_decode
    import router_pkg::*;
#(
    parameter int unsigned AURORA_DATA_WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH             = 10,
    parameter int unsigned RECOGNIZE_ROUTER_WIDTH = 2,
    parameter int unsigned LOCAL_ROUTER_ID        = 0
) (
    input  logic [AURORA_DATA_WIDTH-1:0]      flit,
    output logic [RECOGNIZE_ROUTER_WIDTH-1:0] dst_router,
    output logic [ADDR_WIDTH-1:0]             dst_addr,
    output logic [TTL_W-1:0]                  ttl,
    output logic [PN_W-1:0]                   pkt_number,
    output logic [SRC_W-1:0]                  src_router,
    output logic [HDR_PKT_W-1:0]              header_pkt,
    output logic                              is_local
);

    logic unused_hi;

    assign header_pkt = flit[0 +: HDR_PKT_W];
    assign src_router = flit[SRC_LSB +: SRC_W];
    assign pkt_number = flit[PN_LSB +: PN_W];
    assign ttl        = flit[TTL_LSB +: TTL_W];
    assign dst_addr   = flit[ADDR_LSB +: ADDR_WIDTH];
    assign dst_router = flit[DST_LSB +: RECOGNIZE_ROUTER_WIDTH];
    assign is_local   = (dst_router == RECOGNIZE_ROUTER_WIDTH'(LOCAL_ROUTER_ID));

    assign unused_hi = ^flit[AURORA_DATA_WIDTH-1:DST_LSB+RECOGNIZE_ROUTER_WIDTH];

endmodule

// File: rtl/router_rx_controller.sv
// Receive-side packet controller: pops flits from the RX FIFO, writes local
// payloads to memory under arbiter grant, forwards or drops transit packets.
module router_rx_controller
    import router_pkg::*;
#(
    parameter int unsigned AURORA_DATA_WIDTH      = 64,
    parameter int unsigned ADDR_WIDTH             = 10,
    parameter int unsigned NUMBER_PACKET          = 19,
    parameter int unsigned RECOGNIZE_ROUTER_WIDTH = 2,
    parameter int unsigned PAYLOAD_WORDS          = 1,
    parameter int unsigned LOCAL_ROUTER_ID        = 0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         empty_output_port_0,
    input  logic [AURORA_DATA_WIDTH-1:0] data_output_port_0,
    output logic                         rd_output_port_0,
    input  logic                         arbiter_write_gnt,
    output logic                         arbiter_write_req,
    output logic [ADDR_WIDTH-1:0]        arbiter_dst_addr,
    output logic                         mem_we,
    output logic [AURORA_DATA_WIDTH-1:0] mem_wdata,
    input  logic                         full_output_port_1,
    output logic                         we_output_port_1,
    output logic [AURORA_DATA_WIDTH-1:0] data_port1_after,
    output logic [HDR_PKT_W-1:0]         header_pkt_recv,
    output logic                         rx_done,
    output logic                         seq_err,
    output logic                         drop_pkt
);

    localparam int unsigned CNT_W = $clog2(PAYLOAD_WORDS + 1);

    rx_state_t                        state, state_nxt;
    logic [AURORA_DATA_WIDTH-1:0]     hdr_q;
    logic [ADDR_WIDTH-1:0]            wr_addr;
    logic [CNT_W-1:0]                 pop_cnt, done_cnt;
    logic                             pop_d;
    logic                             hdr_sent;
    logic [PN_W-1:0]                  expected_seq;
    logic                             rd_c;
    logic                             pop_ok, last_word;

    logic [RECOGNIZE_ROUTER_WIDTH-1:0] dec_dst_unused;
    logic [SRC_W-1:0]                  dec_src_unused;
    logic [ADDR_WIDTH-1:0]             dec_addr;
    logic [TTL_W-1:0]                  dec_ttl;
    logic [PN_W-1:0]                   dec_pn;
    logic                              dec_local;
    logic                              unused_dec;
    logic [AURORA_DATA_WIDTH-1:0]      fwd_hdr;

    router_hdr_decode #(
        .AURORA_DATA_WIDTH      (AURORA_DATA_WIDTH),
        .ADDR_WIDTH             (ADDR_WIDTH),
        .RECOGNIZE_ROUTER_WIDTH (RECOGNIZE_ROUTER_WIDTH),
        .LOCAL_ROUTER_ID        (LOCAL_ROUTER_ID)
    ) u_hdr_decode (
        .flit       (hdr_q),
        .dst_router (dec_dst_unused),
        .dst_addr   (dec_addr),
        .ttl        (dec_ttl),
        .pkt_number (dec_pn),
        .src_router (dec_src_unused),
        .header_pkt (header_pkt_recv),
        .is_local   (dec_local)
    );

    assign unused_dec = ^{dec_dst_unused, dec_src_unused};

    assign fwd_hdr   = {hdr_q[AURORA_DATA_WIDTH-1:TTL_LSB+TTL_W],
                        TTL_W'(dec_ttl - 2'd1), hdr_q[TTL_LSB-1:0]};
    assign pop_ok    = (pop_cnt < CNT_W'(PAYLOAD_WORDS));
    assign last_word = (done_cnt == CNT_W'(PAYLOAD_WORDS - 1));

    // IDLE pops combinationally from empty, so the pop is masked while in reset
    assign rd_output_port_0 = rd_c && !rst;
    assign arbiter_dst_addr = wr_addr;

    always_comb begin
        state_nxt         = state;
        rd_c              = 1'b0;
        arbiter_write_req = 1'b0;
        mem_we            = 1'b0;
        mem_wdata         = '0;
        we_output_port_1  = 1'b0;
        data_port1_after  = '0;
        rx_done           = 1'b0;
        seq_err           = 1'b0;
        drop_pkt          = 1'b0;
        case (state)
            S_IDLE: begin
                if (!empty_output_port_0) begin
                    rd_c      = 1'b1;
                    state_nxt = S_HDR;
                end
            end
            S_HDR:      state_nxt = S_CLASSIFY;
            S_CLASSIFY: begin
                if (dec_local)             state_nxt = S_ARB;
                else if (dec_ttl != '0)    state_nxt = S_FWD;
                else                       state_nxt = S_DROP;
            end
            S_ARB: begin
                arbiter_write_req = 1'b1;
                if (arbiter_write_gnt) state_nxt = S_WR;
            end
            S_WR: begin
                arbiter_write_req = 1'b1;
                rd_c              = !empty_output_port_0 && pop_ok;
                if (pop_d) begin
                    mem_we    = 1'b1;
                    mem_wdata = data_output_port_0;
                    if (last_word) state_nxt = S_SEQ;
                end
            end
            S_SEQ: begin
                seq_err   = (dec_pn != expected_seq);
                rx_done   = (dec_pn == PN_W'(NUMBER_PACKET - 1));
                state_nxt = S_IDLE;
            end
            S_FWD: begin
                if (!hdr_sent) begin
                    we_output_port_1 = !full_output_port_1;
                    data_port1_after = full_output_port_1 ? '0 : fwd_hdr;
                end
                // Payload pops wait for space so the next-cycle push always lands
                rd_c = hdr_sent && !empty_output_port_0 && !full_output_port_1 && pop_ok;
                if (pop_d) begin
                    we_output_port_1 = 1'b1;
                    data_port1_after = data_output_port_0;
                    if (last_word) state_nxt = S_IDLE;
                end
            end
            S_DROP: begin
                rd_c = !empty_output_port_0 && pop_ok;
                if (pop_d && last_word) begin
                    drop_pkt  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= S_IDLE;
            hdr_q        <= '0;
            wr_addr      <= '0;
            pop_cnt      <= '0;
            done_cnt     <= '0;
            pop_d        <= 1'b0;
            hdr_sent     <= 1'b0;
            expected_seq <= '0;
        end else begin
            state <= state_nxt;
            pop_d <= rd_c && (state != S_IDLE);
            if (state == S_HDR) hdr_q <= data_output_port_0;
            if (state == S_CLASSIFY) begin
                wr_addr  <= dec_addr + ADDR_WIDTH'(dec_pn) * ADDR_WIDTH'(PAYLOAD_WORDS);
                pop_cnt  <= '0;
                done_cnt <= '0;
                hdr_sent <= 1'b0;
            end
            if (rd_c && state != S_IDLE) pop_cnt <= pop_cnt + 1'b1;
            if (pop_d) begin
                done_cnt <= done_cnt + 1'b1;
                if (state == S_WR) wr_addr <= wr_addr + 1'b1;
            end
            if (state == S_FWD && !hdr_sent && !full_output_port_1) hdr_sent <= 1'b1;
            if (state == S_SEQ) begin
                expected_seq <= (dec_pn == PN_W'(NUMBER_PACKET - 1)) ? '0 : dec_pn + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_router_rx_controller.sv
// Directed, table-driven bench for router_rx_controller with FIFO, grant and
// output-port models plus hand-written backpressure and reset sequences.
module tb_router_rx_controller;

    localparam int unsigned DW = 64;
    localparam int unsigned AW = 10;
    localparam logic [DW-1:0] SENTINEL = 64'hDEAD_BEEF_0BAD_F00D;

    logic          clk;
    logic          rst;
    logic          empty_output_port_0;
    logic [DW-1:0] data_output_port_0;
    logic          rd_output_port_0;
    logic          arbiter_write_gnt;
    logic          arbiter_write_req;
    logic [AW-1:0] arbiter_dst_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic          full_output_port_1;
    logic          we_output_port_1;
    logic [DW-1:0] data_port1_after;
    logic [8:0]    header_pkt_recv;
    logic          rx_done;
    logic          seq_err;
    logic          drop_pkt;

    router_rx_controller #(
        .AURORA_DATA_WIDTH      (64),
        .ADDR_WIDTH             (10),
        .NUMBER_PACKET          (19),
        .RECOGNIZE_ROUTER_WIDTH (2),
        .PAYLOAD_WORDS          (1),
        .LOCAL_ROUTER_ID        (0)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .empty_output_port_0 (empty_output_port_0),
        .data_output_port_0  (data_output_port_0),
        .rd_output_port_0    (rd_output_port_0),
        .arbiter_write_gnt   (arbiter_write_gnt),
        .arbiter_write_req   (arbiter_write_req),
        .arbiter_dst_addr    (arbiter_dst_addr),
        .mem_we              (mem_we),
        .mem_wdata           (mem_wdata),
        .full_output_port_1  (full_output_port_1),
        .we_output_port_1    (we_output_port_1),
        .data_port1_after    (data_port1_after),
        .header_pkt_recv     (header_pkt_recv),
        .rx_done             (rx_done),
        .seq_err             (seq_err),
        .drop_pkt            (drop_pkt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // RX FIFO model: registered empty, data valid the cycle after a pop
    logic [DW-1:0] rxq[$];
    int pop_empty_cnt = 0;
    initial begin
        empty_output_port_0 = 1'b1;
        data_output_port_0  = '0;
    end
    always @(posedge clk) begin
        if (rd_output_port_0) begin
            if (rxq.size() == 0) begin
                pop_empty_cnt++;
                data_output_port_0 <= SENTINEL;
            end else begin
                data_output_port_0 <= rxq.pop_front();
            end
        end else begin
            data_output_port_0 <= SENTINEL;
        end
        empty_output_port_0 <= (rxq.size() == 0);
    end

    // Grant model: grant gnt_dly cycles after request is first seen
    int gnt_dly = 0;
    int req_cyc = 0;
    initial arbiter_write_gnt = 1'b0;
    always @(negedge clk) begin
        if (arbiter_write_req) begin
            if (req_cyc >= gnt_dly) arbiter_write_gnt = 1'b1;
            req_cyc++;
        end else begin
            req_cyc = 0;
            arbiter_write_gnt = 1'b0;
        end
    end

    // Output monitor (sole owner of these counters and logs)
    int n_we = 0, n_push = 0, n_drop = 0, n_err = 0, n_done = 0, n_req = 0;
    int n_pop_full = 0, n_push_full = 0;
    logic [AW-1:0] we_addr_q[$];
    logic [DW-1:0] we_data_q[$];
    logic [DW-1:0] push_q[$];
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_we) begin
                n_we++;
                we_addr_q.push_back(arbiter_dst_addr);
                we_data_q.push_back(mem_wdata);
            end
            if (we_output_port_1) begin
                n_push++;
                push_q.push_back(data_port1_after);
            end
            if (drop_pkt)          n_drop++;
            if (seq_err)           n_err++;
            if (rx_done)           n_done++;
            if (arbiter_write_req) n_req++;
            if (full_output_port_1 && rd_output_port_0)  n_pop_full++;
            if (full_output_port_1 && we_output_port_1)  n_push_full++;
        end
    end

    typedef struct {
        logic [1:0]  dst;
        logic [9:0]  addr;
        logic [1:0]  ttl;
        logic [4:0]  num;
        logic [1:0]  src;
        logic [63:0] payload;
        int          dly;
        int          exp_we;
        logic [9:0]  exp_waddr;
        int          exp_req;
        int          exp_push;
        logic [1:0]  exp_fwd_ttl;
        int          exp_drop;
        int          exp_err;
        int          exp_done;
    } vec_t;

    vec_t vecs[27];

    function automatic logic [63:0] mk_hdr(input logic [1:0] dst, input logic [9:0] addr,
                                           input logic [1:0] ttl, input logic [4:0] num,
                                           input logic [1:0] src);
        return {43'h123_4567_89AB, dst, addr, ttl, num, src};
    endfunction

    function automatic vec_t mk_local(input logic [9:0] addr, input logic [1:0] ttl,
                                      input logic [4:0] num, input logic [1:0] src,
                                      input logic [63:0] pl, input int dly,
                                      input logic [9:0] waddr, input int err, input int done);
        vec_t v;
        v.dst = 2'd0; v.addr = addr; v.ttl = ttl; v.num = num; v.src = src; v.payload = pl;
        v.dly = dly; v.exp_we = 1; v.exp_waddr = waddr; v.exp_req = dly + 3;
        v.exp_push = 0; v.exp_fwd_ttl = 2'd0; v.exp_drop = 0; v.exp_err = err; v.exp_done = done;
        return v;
    endfunction

    function automatic vec_t mk_remote(input logic [1:0] dst, input logic [1:0] ttl,
                                       input logic [4:0] num, input logic [1:0] src,
                                       input logic [63:0] pl, input int push,
                                       input logic [1:0] fttl, input int drop);
        vec_t v;
        v.dst = dst; v.addr = 10'h155; v.ttl = ttl; v.num = num; v.src = src; v.payload = pl;
        v.dly = 0; v.exp_we = 0; v.exp_waddr = '0; v.exp_req = 0;
        v.exp_push = push; v.exp_fwd_ttl = fttl; v.exp_drop = drop; v.exp_err = 0; v.exp_done = 0;
        return v;
    endfunction

    task automatic run_vec(input int idx);
        vec_t v;
        logic [63:0] hdr, fh;
        int b_we, b_push, b_drop, b_err, b_done, b_req, wi, pi;
        v = vecs[idx];
        b_we = n_we; b_push = n_push; b_drop = n_drop; b_err = n_err; b_done = n_done; b_req = n_req;
        wi = we_addr_q.size(); pi = push_q.size();
        hdr = mk_hdr(v.dst, v.addr, v.ttl, v.num, v.src);
        gnt_dly = v.dly;
        @(negedge clk);
        rxq.push_back(hdr);
        rxq.push_back(v.payload);
        repeat (30) @(negedge clk);
        chk($sformatf("v%0d_we_count", idx),   n_we - b_we,     v.exp_we);
        chk($sformatf("v%0d_req_cycles", idx), n_req - b_req,   v.exp_req);
        chk($sformatf("v%0d_push_count", idx), n_push - b_push, v.exp_push);
        chk($sformatf("v%0d_drop", idx),       n_drop - b_drop, v.exp_drop);
        chk($sformatf("v%0d_seq_err", idx),    n_err - b_err,   v.exp_err);
        chk($sformatf("v%0d_rx_done", idx),    n_done - b_done, v.exp_done);
        chk($sformatf("v%0d_hdr_recv", idx),   header_pkt_recv, {v.ttl, v.num, v.src});
        chk($sformatf("v%0d_drained", idx),    rxq.size(),      0);
        if (v.exp_we == 1 && we_addr_q.size() > wi) begin
            chk($sformatf("v%0d_waddr", idx), we_addr_q[wi], v.exp_waddr);
            chk($sformatf("v%0d_wdata", idx), we_data_q[wi], v.payload);
        end
        if (v.exp_push == 2 && push_q.size() > pi + 1) begin
            fh = mk_hdr(v.dst, v.addr, v.exp_fwd_ttl, v.num, v.src);
            chk($sformatf("v%0d_fwd_hdr", idx), push_q[pi],     fh);
            chk($sformatf("v%0d_fwd_pl", idx),  push_q[pi + 1], v.payload);
        end
    endtask

    initial begin
        int b_push, b_pf, b_psf, b_we, pi, waited;
        logic [63:0] fh;

        vecs[0] = mk_local(10'h040, 2'd2, 5'd0, 2'd1, 64'hA5A5, 3, 10'h040, 0, 0);
        for (int i = 1; i <= 18; i++)
            vecs[i] = mk_local(10'h100, 2'd2, 5'(i), 2'd2, 64'h1000 + 64'(i), i % 3,
                               10'h100 + 10'(i), 0, (i == 18) ? 1 : 0);
        vecs[19] = mk_remote(2'd1, 2'd2, 5'd7, 2'd3, 64'hBEEF, 2, 2'd1, 0);
        vecs[20] = mk_remote(2'd3, 2'd1, 5'd9, 2'd0, 64'h7777_0000_1111, 2, 2'd0, 0);
        vecs[21] = mk_remote(2'd2, 2'd0, 5'd4, 2'd1, 64'hD0D0, 0, 2'd0, 1);
        vecs[22] = mk_local(10'h200, 2'd2, 5'd0, 2'd1, 64'h2222, 1, 10'h200, 0, 0);
        vecs[23] = mk_local(10'h200, 2'd2, 5'd2, 2'd1, 64'h3333, 0, 10'h202, 1, 0);
        vecs[24] = mk_local(10'h3FE, 2'd2, 5'd3, 2'd1, 64'h4444, 2, 10'h001, 0, 0);
        vecs[25] = mk_local(10'h010, 2'd0, 5'd4, 2'd3, 64'h5555, 0, 10'h014, 0, 0);
        vecs[26] = mk_local(10'h050, 2'd2, 5'd0, 2'd1, 64'h600D, 0, 10'h050, 0, 0);

        rst = 1'b1;
        full_output_port_1 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            {rd_output_port_0, arbiter_write_req, mem_we, we_output_port_1, rx_done, seq_err, drop_pkt}, 7'd0);
        chk("reset_hdr_recv", header_pkt_recv, 9'd0);
        chk("reset_addr", arbiter_dst_addr, 10'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i <= 25; i++) run_vec(i);

        // Transit packet under output backpressure
        b_push = n_push; b_pf = n_pop_full; b_psf = n_push_full; b_we = n_we;
        pi = push_q.size();
        full_output_port_1 = 1'b1;
        rxq.push_back(mk_hdr(2'd1, 10'h0AA, 2'd2, 5'd5, 2'd0));
        rxq.push_back(64'hCAFE_F00D);
        repeat (8) @(negedge clk);
        chk("bp_pops_while_full", n_pop_full - b_pf, 1);
        chk("bp_push_while_full", n_push_full - b_psf, 0);
        chk("bp_no_push_yet", n_push - b_push, 0);
        full_output_port_1 = 1'b0;
        repeat (20) @(negedge clk);
        chk("bp_push_count", n_push - b_push, 2);
        chk("bp_no_write", n_we - b_we, 0);
        if (push_q.size() > pi + 1) begin
            fh = mk_hdr(2'd1, 10'h0AA, 2'd1, 5'd5, 2'd0);
            chk("bp_fwd_hdr", push_q[pi], fh);
            chk("bp_fwd_pl", push_q[pi + 1], 64'hCAFE_F00D);
        end
        chk("bp_drained", rxq.size(), 0);

        // Reset while stalled in the write phase with no payload available
        gnt_dly = 0;
        b_we = n_we;
        rxq.push_back(mk_hdr(2'd0, 10'h030, 2'd2, 5'd9, 2'd1));
        waited = 0;
        while (!arbiter_write_req && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        chk("rst_req_seen", arbiter_write_req, 1'b1);
        @(negedge clk);
        chk("rst_wr_req_held", arbiter_write_req, 1'b1);
        chk("rst_pre_hdr", header_pkt_recv, {2'd2, 5'd9, 2'd1});
        rst = 1'b1;
        #1;
        chk("rst_mid_outputs",
            {rd_output_port_0, arbiter_write_req, mem_we, we_output_port_1, rx_done, seq_err, drop_pkt}, 7'd0);
        chk("rst_mid_addr", arbiter_dst_addr, 10'd0);
        chk("rst_mid_wdata", mem_wdata, 64'd0);
        chk("rst_mid_hdr_recv", header_pkt_recv, 9'd0);
        chk("rst_mid_no_write", n_we - b_we, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_vec(26);

        chk("no_pop_when_empty", pop_empty_cnt, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
